// File: rtl/uart_cmd_pkg.sv
// Shared constants, types and command ROM contents for the UART command receiver.
package uart_cmd_pkg;

  localparam int unsigned DefaultLineLen    = 32;
  localparam int unsigned DefaultMsgCount   = 8;
  localparam int unsigned DefaultRomLatency = 2;

  localparam logic [7:0] CharCr = 8'h0D;
  localparam logic [7:0] CharLf = 8'h0A;

  typedef enum logic [1:0] {StReceive, StDiscard, StMatch, StDone} state_e;

  typedef logic [2:0] cmd_id_t;

  localparam cmd_id_t CmdLed    = 3'd0;
  localparam cmd_id_t CmdHello  = 3'd1;
  localparam cmd_id_t CmdReset  = 3'd2;
  localparam cmd_id_t CmdTest   = 3'd3;
  localparam cmd_id_t CmdEcho   = 3'd4;
  localparam cmd_id_t CmdStatus = 3'd5;
  localparam cmd_id_t CmdLoop   = 3'd6;
  localparam cmd_id_t CmdOff    = 3'd7;

  // Each command string is left-justified in 8 bytes and null padded; slot bytes 8+ are 0x00.
  localparam int unsigned CmdStrBytes = 8;

  function automatic logic [7:0] cmd_rom_byte(input cmd_id_t slot, input int unsigned idx);
    logic [8*CmdStrBytes-1:0] str;
    logic [8*CmdStrBytes-1:0] shifted;
    unique case (slot)
      CmdLed:    str = {"LED", 40'h0};
      CmdHello:  str = {"HELLO", 24'h0};
      CmdReset:  str = {"RESET", 24'h0};
      CmdTest:   str = {"TEST", 32'h0};
      CmdEcho:   str = {"ECHO", 32'h0};
      CmdStatus: str = {"STATUS", 16'h0};
      CmdLoop:   str = {"LOOP", 32'h0};
      default:   str = {"OFF", 40'h0};
    endcase
    shifted = str << (8 * idx);
    if (idx >= CmdStrBytes) begin
      return 8'h00;
    end
    return shifted[8*CmdStrBytes-1 -: 8];
  endfunction

endpackage

// File: rtl/uart_commands.sv
// Command string ROM: 8 slots of null-terminated strings, registered address and output.
module uart_commands
  import uart_cmd_pkg::*;
#(
  parameter int unsigned IdxW  = 5,
  parameter int unsigned AddrW = 3 + IdxW
) (
  input  logic             clock,
  input  logic [AddrW-1:0] address,
  output logic [7:0]       data
);

  logic [AddrW-1:0] addr_q;
  logic [7:0]       data_q;

  always_ff @(posedge clock) begin
    addr_q <= address;
    data_q <= cmd_rom_byte(cmd_id_t'(addr_q[AddrW-1:IdxW]), 32'(addr_q[IdxW-1:0]));
  end

  assign data = data_q;

endmodule

// File: rtl/uart_receive_command.sv
// Buffers a UART line up to CR/LF, then walks the command ROM slot by slot looking
// for an exact match and reports the command id, unknown, or overflow.
module uart_receive_command
  import uart_cmd_pkg::*;
#(
  parameter int unsigned LineLen    = DefaultLineLen,
  parameter int unsigned MsgCount   = DefaultMsgCount,
  parameter int unsigned RomLatency = DefaultRomLatency
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       uart_rx_byte_ready,
  input  logic [7:0] uart_rx_byte,
  output logic       busy,
  output logic       command_valid,
  output logic [2:0] command_id,
  output logic       command_unknown,
  output logic       command_overflow,
  output logic       rx_dropped
);

  localparam int unsigned LenW  = $clog2(LineLen);
  localparam int unsigned WaitW = $clog2(RomLatency + 1);
  localparam logic [LenW-1:0]  MaxLen   = LenW'(LineLen - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RomLatency);
  localparam cmd_id_t          LastSlot = cmd_id_t'(MsgCount - 1);

  state_e            state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   idx_q, idx_d;
  cmd_id_t           slot_q, slot_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              valid_q, valid_d;
  logic              unknown_q, unknown_d;
  logic              overflow_q, overflow_d;
  cmd_id_t           id_q, id_d;
  logic [7:0]        line_q [LineLen];
  logic [7:0]        rom_data;
  logic              store_en;
  logic              is_term;

  uart_commands #(
    .IdxW (LenW)
  ) u_rom (
    .clock   (clock),
    .address ({slot_q, idx_q}),
    .data    (rom_data)
  );

  assign is_term = (uart_rx_byte == CharCr) || (uart_rx_byte == CharLf);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    wait_d     = wait_q;
    valid_d    = 1'b0;
    unknown_d  = 1'b0;
    overflow_d = 1'b0;
    id_d       = id_q;
    store_en   = 1'b0;
    unique case (state_q)
      StReceive: begin
        if (uart_rx_byte_ready) begin
          if (!is_term) begin
            if (len_q < MaxLen) begin
              store_en = 1'b1;
              len_d    = len_q + LenW'(1);
            end else begin
              state_d = StDiscard;
            end
          end else if (len_q != '0) begin
            state_d = StMatch;
            slot_d  = '0;
            idx_d   = '0;
            wait_d  = '0;
          end
        end
      end
      StDiscard: begin
        if (uart_rx_byte_ready && is_term) begin
          overflow_d = 1'b1;
          len_d      = '0;
          state_d    = StReceive;
        end
      end
      StMatch: begin
        // Address is held for RomLatency extra clocks before rom_data belongs to it.
        if (wait_q != WaitLast) begin
          wait_d = wait_q + WaitW'(1);
        end else begin
          wait_d = '0;
          if ((idx_q < len_q) && (rom_data == line_q[idx_q])) begin
            idx_d = idx_q + LenW'(1);
          end else if ((idx_q == len_q) && (rom_data == 8'h00)) begin
            valid_d = 1'b1;
            id_d    = slot_q;
            state_d = StDone;
          end else if (slot_q < LastSlot) begin
            slot_d = slot_q + 3'd1;
            idx_d  = '0;
          end else begin
            unknown_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        len_d   = '0;
        state_d = StReceive;
      end
      default: state_d = StReceive;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StReceive;
      len_q      <= '0;
      idx_q      <= '0;
      slot_q     <= '0;
      wait_q     <= '0;
      valid_q    <= 1'b0;
      unknown_q  <= 1'b0;
      overflow_q <= 1'b0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      wait_q     <= wait_d;
      valid_q    <= valid_d;
      unknown_q  <= unknown_d;
      overflow_q <= overflow_d;
      id_q       <= id_d;
    end
  end

  always_ff @(posedge clock) begin
    if (store_en) begin
      line_q[len_q] <= uart_rx_byte;
    end
  end

  assign busy             = (state_q == StMatch);
  assign rx_dropped       = uart_rx_byte_ready && ((state_q == StMatch) || (state_q == StDone));
  assign command_valid    = valid_q;
  assign command_unknown  = unknown_q;
  assign command_overflow = overflow_q;
  assign command_id       = id_q;

endmodule
